// File: rtl/node_mac_seq.sv
// Sequential neuron: one signed multiply-accumulate per cycle over NIN inputs,
// then a floor shift by FRAC, saturation to DW bits and optional ReLU.
module node_mac_seq #(
  parameter int                      DW     = 16,
  parameter int                      NIN    = 15,
  parameter int                      FRAC   = 0,
  parameter logic [NIN*DW-1:0]       W_INIT = '0,
  parameter logic signed [DW-1:0]    BIAS   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIN*DW-1:0] in_vec,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              act_mode,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat,
  output logic [1:0]        o_dbg_state
);

  // Handshakes: a transfer happens on any rising edge where valid & ready are
  // both high; valid never depends on ready, and the result holds until taken.

  localparam int AW = 2*DW + $clog2(NIN) + 1;
  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [IW-1:0]        LAST = IW'(NIN-1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_started;
  logic [NIN*DW-1:0]     r_x;
  logic                  r_act;
  logic [IW-1:0]         r_idx;
  logic signed [AW-1:0]  r_acc;
  logic [DW-1:0]         r_out_data;
  logic                  r_out_sat;

  logic                  w_accept;
  logic                  w_last;
  logic signed [DW-1:0]  w_x;
  logic signed [DW-1:0]  w_w;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_shift;
  logic signed [AW-1:0]  w_bias_init;
  logic [DW-1:0]         w_res;
  logic                  w_sat;

  // r_started keeps in_ready low while reset is held and for no longer.
  assign in_ready    = (r_state == IDLE) && r_started;
  assign out_valid   = (r_state == OUT);
  assign out_data    = r_out_data;
  assign out_sat     = r_out_sat;
  assign o_dbg_state = r_state;

  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_idx == LAST);
  assign w_x         = r_x[r_idx*DW +: DW];
  assign w_w         = W_INIT[r_idx*DW +: DW];
  assign w_prod      = w_x * w_w;
  assign w_sum       = r_acc + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_bias_init = $signed({{(AW-DW){BIAS[DW-1]}}, BIAS}) <<< FRAC;
  assign w_shift     = w_sum >>> FRAC;

  always_comb begin
    w_res = w_shift[DW-1:0];
    w_sat = 1'b0;
    if (w_shift > MAXV) begin
      w_res = MAXV[DW-1:0];
      w_sat = 1'b1;
    end else if (w_shift < MINV) begin
      w_res = MINV[DW-1:0];
      w_sat = 1'b1;
    end
    if (!r_act && w_res[DW-1]) w_res = '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = MAC;
      MAC:     if (w_last) w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_started  <= 1'b0;
      r_x        <= '0;
      r_act      <= 1'b0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= in_vec;
            r_act <= act_mode;
            r_idx <= '0;
            r_acc <= w_bias_init;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_idx      <= '0;
            r_out_data <= w_res;
            r_out_sat  <= w_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_mac_seq.sv
// Bench for node_mac_seq: two instances (FRAC=0 and FRAC=2), directed and
// random vectors scored against an arithmetic model of the neuron.
module tb_node_mac_seq;

  localparam int NIN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [47:0] in_vec = '0;
  logic        in_valid_a = 1'b0;
  logic        in_valid_b = 1'b0;
  logic        act_mode = 1'b1;
  logic        out_ready = 1'b1;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_sat_a, out_sat_b;
  logic [15:0] out_data_a, out_data_b;
  logic [1:0]  dbg_a, dbg_b;

  int          n_checks = 0;
  int          n_pass = 0;
  longint      last_acc = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  node_mac_seq #(.DW(16), .NIN(3), .FRAC(0),
                 .W_INIT({16'h0001, 16'hFFFD, 16'h0002}), .BIAS(16'sd5)) u_a (
    .clk(clk), .reset(reset), .in_vec(in_vec), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .act_mode(act_mode), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sat(out_sat_a),
    .o_dbg_state(dbg_a));

  node_mac_seq #(.DW(16), .NIN(3), .FRAC(2),
                 .W_INIT({16'h0004, 16'h0004, 16'h0004}), .BIAS(16'sd1)) u_b (
    .clk(clk), .reset(reset), .in_vec(in_vec), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .act_mode(act_mode), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sat(out_sat_b),
    .o_dbg_state(dbg_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [47:0] pack(input int a, input int b, input int c);
    return {c[15:0], b[15:0], a[15:0]};
  endfunction

  // Neuron behaviour from first principles: sum, floor divide by 2^FRAC,
  // clamp, then ReLU; result is {sat, data}.
  function automatic logic [16:0] model(input bit sel, input logic [47:0] v, input logic act);
    longint w[3];
    longint bias, s;
    int     frac;
    logic   sat;
    if (sel) begin w = '{4, 4, 4};  bias = 1; frac = 2; end
    else     begin w = '{2, -3, 1}; bias = 5; frac = 0; end
    s = bias * (longint'(1) << frac);
    for (int i = 0; i < 3; i++) s += longint'($signed(v[i*16 +: 16])) * w[i];
    s = s >>> frac;
    sat = 1'b0;
    if (s > 32767)       begin s = 32767;  sat = 1'b1; end
    else if (s < -32768) begin s = -32768; sat = 1'b1; end
    if (!act && s < 0) s = 0;
    return {sat, s[15:0]};
  endfunction

  function automatic logic [16:0] res(input bit sel);
    return sel ? {out_sat_b, out_data_b} : {out_sat_a, out_data_a};
  endfunction
  function automatic logic vld(input bit sel);
    return sel ? out_valid_b : out_valid_a;
  endfunction
  function automatic logic rdy(input bit sel);
    return sel ? in_ready_b : in_ready_a;
  endfunction

  function automatic int rnd_elem();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 1) ? 32767 : -32768;
      1:       return int'($signed(16'($urandom())));
      default: return int'($urandom_range(0, 40)) - 20;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the result was taken.
  task automatic run_vec(input bit sel, input logic [47:0] v, input logic act,
                         input int stall, input logic [16:0] exp, input bit tp);
    int          k;
    logic [16:0] held;
    logic [16:0] e;
    k = 0;
    while (!rdy(sel) && k < 20) begin @(negedge clk); k++; end
    chk("in_ready_wait", 32'(k < 20), 1);
    if (tp) chk("period", 32'(($time - last_acc) / 10), NIN + 2);
    last_acc = $time;
    in_vec = v; act_mode = act; out_ready = (stall == 0);
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_vec = 48'({$urandom(), $urandom()}); act_mode = ~act;
    chk("in_ready_busy", 32'(rdy(sel)), 0);
    k = 1;
    while (!vld(sel) && k < 20) begin
      @(negedge clk); k++;
      in_vec = 48'({$urandom(), $urandom()});
    end
    chk("latency", k, NIN + 1);
    held = res(sel);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_vec = 48'({$urandom(), $urandom()});
      chk("hold_data", 32'(res(sel)), 32'(held));
      chk("hold_valid", 32'(vld(sel)), 1);
      chk("hold_in_ready", 32'(rdy(sel)), 0);
    end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    chk("result", 32'(res(sel)), 32'(e));
    @(negedge clk);
    chk("valid_drop", 32'(vld(sel)), 0);
    chk("in_ready_back", 32'(rdy(sel)), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;
    bit sel;
    logic [47:0] v;
    logic act;
    #1;
    chk("rst_in_ready", 32'(in_ready_a), 0);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_out", 32'(res(0)), 0);
    chk("rst_state", 32'(dbg_a), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("first_in_ready", 32'({in_ready_a, in_ready_b}), 3);

    run_vec(0, pack(4, 1, 7), 1'b1, 0, 17'h00011, 1'b0);
    run_vec(0, pack(4, 1, 7), 1'b1, 0, 17'h00011, 1'b1);
    run_vec(0, pack(0, 5, 0), 1'b1, 0, 17'h0FFF6, 1'b1);
    run_vec(0, pack(0, 5, 0), 1'b0, 0, 17'h00000, 1'b1);
    run_vec(0, pack(32767, 0, 0), 1'b1, 0, 17'h17FFF, 1'b0);
    run_vec(0, pack(0, 32767, 32767), 1'b1, 0, 17'h18000, 1'b0);
    run_vec(0, pack(-32768, 0, 0), 1'b1, 0, 17'h18000, 1'b0);
    run_vec(0, pack(-32768, 0, 0), 1'b0, 0, 17'h10000, 1'b0);
    run_vec(0, pack(4, 1, 7), 1'b1, 5, 17'h00011, 1'b0);
    run_vec(1, pack(-1, 0, 0), 1'b1, 0, 17'h00000, 1'b0);
    run_vec(1, pack(-2, 0, 0), 1'b1, 0, 17'h0FFFF, 1'b0);
    run_vec(1, pack(-2, 0, 0), 1'b0, 2, 17'h00000, 1'b0);

    // Abort a vector with reset while the accumulator is at index 1.
    in_vec = pack(4, 1, 7); act_mode = 1'b1; in_valid_a = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    @(negedge clk);
    chk("abort_in_mac", 32'(dbg_a), 1);
    reset = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready_a), 0);
    chk("abort_valid", 32'(out_valid_a), 0);
    chk("abort_state", 32'(dbg_a), 0);
    chk("abort_out", 32'(res(0)), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", 32'(in_ready_a), 1);
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid_a) seen++; end
    chk("no_stale", seen, 0);
    run_vec(0, pack(4, 1, 7), 1'b1, 0, 17'h00011, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(0, 1));
      v   = pack(rnd_elem(), rnd_elem(), rnd_elem());
      act = 1'($urandom_range(0, 1));
      run_vec(sel, v, act, $urandom_range(0, 3), model(sel, v, act), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
